// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width.
package arith_pkg;

  localparam int ADDER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } adder_state_t;

endpackage

// File: rtl/full_adder_d.sv
// One-bit full-adder slice built from two half adders and an OR gate.
module full_adder_d (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic p;
  logic g;
  logic t;

  half_adder_d u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (p),
    .c_o (g)
  );

  half_adder_d u_ha1 (
    .a_i (p),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (t)
  );

  // Carry out is generate OR (propagate AND carry-in)
  always_comb begin
    co_o = g | t;
  end

endmodule

// File: rtl/half_adder_d.sv
// One-bit half adder: sum is the XOR, carry is the AND of the two inputs.
module half_adder_d (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  // Purely combinational half-adder cell
  always_comb begin
    s_o = a_i ^ b_i;
    c_o = a_i & b_i;
  end

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: operands captured on start, summed LSB-first through a
// single full-adder slice with a registered carry, one bit per clock.
//
// Handshake: start is a request sampled only while the FSM is IDLE; requests
// arriving during SHIFT or DONE are dropped without queuing. done is a
// one-cycle pulse marking sum/cout valid; they hold until the next accepted
// start. busy and done are registered copies of the state, so they trail the
// internal state by one clock.
module serial_adder_fsm
  import arith_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output adder_state_t     dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q;
  logic             done_q;

  logic fa_s;
  logic fa_co;

  full_adder_d u_fa (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .c_i  (c_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      SHIFT: begin
        res_d = {fa_s, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = fa_co;
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the result; counter stays put so it never wraps
          state_d = DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= (state_q == SHIFT);
      done_q  <= (state_q == DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed and back-to-back checks for the bit-serial adder at WIDTH=8.
module tb_serial_adder_fsm;
  import arith_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  adder_state_t dbg_state;

  int n_cmp;
  int n_err;
  int cyc;

  logic [W:0] exp_q[$];
  logic       mon_en;
  int         mon_last;
  int         mon_dones;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Back-to-back monitor: checks done spacing and result against the queue
  always @(negedge clk) begin
    if (mon_en && done) begin
      if (mon_last >= 0) chk("b2b_spacing", 32'(cyc - mon_last), 32'(W + 2));
      mon_last = cyc;
      mon_dones++;
      if (exp_q.size() == 0) chk("b2b_unexpected_done", 32'd1, 32'd0);
      else chk("b2b_result", 32'({cout, sum}), 32'(exp_q.pop_front()));
    end
  end

  // One operation with optional disturbance in mid-SHIFT:
  // mode 1 pulses start with a=0x11, mode 2 changes a/b/cin.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_s, input logic exp_c,
                        input int mode);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        chk({tag, "_sum_at_done"}, 32'(sum), 32'(exp_s));
        chk({tag, "_cout_at_done"}, 32'(cout), 32'(exp_c));
      end
      if (mode == 1 && i == 3) begin start = 1'b1; a = 8'h11; end
      if (mode == 1 && i == 4) start = 1'b0;
      if (mode == 2 && i == 3) begin a = 8'hFF; b = 8'hFF; cin = ~cv; end
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_edge"}, 32'(done_at), 32'(W + 1));
    chk({tag, "_sum_held"}, 32'(sum), 32'(exp_s));
    chk({tag, "_cout_held"}, 32'(cout), 32'(exp_c));
  endtask

  initial begin
    int dcnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    n_cmp = 0; n_err = 0; cyc = 0;
    mon_en = 1'b0; mon_last = -1; mon_dones = 0;
    rst_n = 1'b0; start = 1'b1; a = 8'h5A; b = 8'hA5; cin = 1'b1;

    // Reset held three cycles with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
    end
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1; start = 1'b0;
    tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // Directed operations
    run_op("basic",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0);
    run_op("carry_ff", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run_op("carry_a5", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
    run_op("ign_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1);
    run_op("ign_ab",  8'h70, 8'h0E, 1'b1, 8'h7F, 1'b0, 2);

    // Reset after four bits: operation aborted, outputs cleared
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("abort_done_pulses", 32'(dcnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    run_op("after_abort", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);

    // Back-to-back random operations with start held high
    mon_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc; start = 1'b1;
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      for (int k = 0; k < W + 2; k++) tick();
    end
    start = 1'b0;
    for (int k = 0; k < 3 * (W + 2); k++) tick();
    mon_en = 1'b0;
    chk("b2b_done_count", 32'(mon_dones), 32'd1000);
    chk("b2b_queue_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
